// File: rtl/luna_vga_top.sv
// Luna display path top: pixel-rate clock enable, 640x480@60 VGA timing, RGB test pattern
// and a frame counter on the LEDs. Define VGA_COLOR_BARS_EN to replace the pattern with 8 colour bars.
module luna_vga_top #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        raw_clk,
  input  logic        rst,
  output logic [15:0] leds,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare code so sync-end boundaries equal to the total still fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int XW = HW + VW + 8;

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [3:0]    red_q, red_d;
  logic [3:0]    green_q, green_d;
  logic [3:0]    blue_q, blue_d;
  logic          pix_en;
  logic          active;
`ifdef VGA_COLOR_BARS_EN
  logic [2:0]    bar;
`endif

  // pix_en is a one-raw-clock strobe; with CLK_DIV=1 DIV_LAST is 0 and it stays high.
  assign pix_en = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d   = pix_en ? '0 : div_cnt_q + DW'(1);
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  // Pixel outputs are decoded from the pre-update counters and registered on pix_en,
  // giving one pixel of latency relative to the counters.
  always_comb begin
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
    vsync_d = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
    red_d   = 4'h0;
    green_d = 4'h0;
    blue_d  = 4'h0;
`ifdef VGA_COLOR_BARS_EN
    bar = 3'((XW'(h_cnt_q) << 3) / XW'(H_ACTIVE));
    if (active) begin
      red_d   = bar[2] ? 4'hF : 4'h0;
      green_d = bar[1] ? 4'hF : 4'h0;
      blue_d  = bar[0] ? 4'hF : 4'h0;
    end
`else
    if (active) begin
      red_d   = 4'(XW'(h_cnt_q) >> 2);
      green_d = 4'(XW'(v_cnt_q) >> 2);
      blue_d  = ((((XW'(h_cnt_q) ^ XW'(v_cnt_q)) >> 6) & XW'(1)) != '0) ? 4'hF : 4'h0;
    end
`endif
  end

  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q   <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      red_q       <= 4'h0;
      green_q     <= 4'h0;
      blue_q      <= 4'h0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (pix_en) begin
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        red_q   <= red_d;
        green_q <= green_d;
        blue_q  <= blue_d;
      end
    end
  end

  assign leds  = frame_cnt_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule

// File: tb/tb_luna_vga_top.sv
// Bench for luna_vga_top: a default-timing instance probed at key pixels and a tiny-timing
// instance checked on every clock against a pixel-index model of the VGA output.
module tb_luna_vga_top;

  localparam int W = 30;
  localparam logic [W-1:0] RST_VAL = {16'h0000, 1'b1, 1'b1, 12'h000};
  localparam int PROBES [13] = '{0, 1, 400, 639, 640, 655, 656, 751, 752, 799, 800, 4071, 4700};

  // clock / reset
  logic raw_clk = 1'b0;
  logic rst = 1'b0;
  always #5 raw_clk = ~raw_clk;

  logic [15:0] b_leds, s_leds;
  logic        b_hs, b_vs, s_hs, s_vs;
  logic [3:0]  b_r, b_g, b_b, s_r, s_g, s_b;

  luna_vga_top dut_big (
    .raw_clk(raw_clk), .rst(rst), .leds(b_leds), .hsync(b_hs), .vsync(b_vs),
    .red(b_r), .green(b_g), .blue(b_b)
  );

  luna_vga_top #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .raw_clk(raw_clk), .rst(rst), .leds(s_leds), .hsync(s_hs), .vsync(s_vs),
    .red(s_r), .green(s_g), .blue(s_b)
  );

  wire [W-1:0] b_obs = {b_leds, b_hs, b_vs, b_r, b_g, b_b};
  wire [W-1:0] s_obs = {s_leds, s_hs, s_vs, s_r, s_g, s_b};

  // scoreboard state
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_s_q[$];
  logic [W-1:0] exp_b_q[$];
  int h_fall[$];
  int h_rise[$];
  int s_p;
  int s_fbase;
  int b_k;
  logic b_hs_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the enable that consumed pixel index p (counted from reset release).
  function automatic logic [W-1:0] vga_model(input int p, input int fbase,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb);
    int ht;
    int vt;
    int h;
    int v;
    int fr;
    int bar;
    logic hsy;
    logic vsy;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    h   = p % ht;
    v   = (p / ht) % vt;
    fr  = fbase + (p + 1) / (ht * vt);
    hsy = !(h >= ha + hf && h < ha + hf + hs);
    vsy = !(v >= va + vf && v < va + vf + vs);
    r = 4'h0;
    g = 4'h0;
    b = 4'h0;
    bar = 0;
    if (h < ha && v < va) begin
`ifdef VGA_COLOR_BARS_EN
      bar = (h * 8) / ha;
      r = ((bar & 4) != 0) ? 4'hF : 4'h0;
      g = ((bar & 2) != 0) ? 4'hF : 4'h0;
      b = ((bar & 1) != 0) ? 4'hF : 4'h0;
`else
      r = 4'((h / 4) % 16);
      g = 4'((v / 4) % 16);
      b = ((((h / 64) + (v / 64)) % 2) != 0) ? 4'hF : 4'h0;
`endif
    end
    return {16'(fr), hsy, vsy, r, g, b};
  endfunction

  function automatic bit is_probe(input int p);
    foreach (PROBES[i]) if (PROBES[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // driver: one raw clock edge, expectations pushed before it, compared #1 after it
  task automatic tick(input bit chk_small);
    logic [W-1:0] e;
    bit big_probe;
    int bp;
    big_probe = 1'b0;
    bp = 0;
    if (chk_small) exp_s_q.push_back(vga_model(s_p, s_fbase, 4, 1, 2, 1, 3, 1, 1, 1));
    s_p++;
    b_k++;
    if (b_k % 4 == 0) begin
      bp = b_k / 4 - 1;
      if (is_probe(bp)) begin
        exp_b_q.push_back(vga_model(bp, 0, 640, 16, 96, 48, 480, 10, 2, 33));
        big_probe = 1'b1;
      end
    end
    @(posedge raw_clk);
    #1;
    if (chk_small) begin
      e = exp_s_q.pop_front();
      check($sformatf("small_px%0d", s_p - 1), 32'(s_obs), 32'(e));
    end
    if (big_probe) begin
      e = exp_b_q.pop_front();
      check($sformatf("big_px%0d", bp), 32'(b_obs), 32'(e));
    end
    if (b_hs_prev && !b_hs) h_fall.push_back(b_k);
    if (!b_hs_prev && b_hs) h_rise.push_back(b_k);
    b_hs_prev = b_hs;
  endtask

  task automatic restart_counts();
    s_p = 0;
    b_k = 0;
    s_fbase = 0;
    b_hs_prev = 1'b1;
    h_fall.delete();
    h_rise.delete();
  endtask

  task automatic check_line_timing(input string tag, input bit full);
    check({tag, "_hs_fall_edge"}, 32'((h_fall.size() > 0) ? h_fall[0] : -1), 32'(2628));
    check({tag, "_hs_low_len"},
          32'((h_rise.size() > 0 && h_fall.size() > 0) ? h_rise[0] - h_fall[0] : -1), 32'(384));
    if (full)
      check({tag, "_line_period"},
            32'((h_fall.size() > 1) ? h_fall[1] - h_fall[0] : -1), 32'(3200));
  endtask

  initial begin
    restart_counts();
    rst = 1'b0;
    repeat (5) @(posedge raw_clk);
    #1;
    check("rst_big", 32'(b_obs), 32'(RST_VAL));
    check("rst_small", 32'(s_obs), 32'(RST_VAL));

    // long run: line timing, pattern probes, two full small frames
    @(negedge raw_clk);
    rst = 1'b1;
    for (int i = 0; i < 18810; i++) tick(i < 100);
    check_line_timing("run1", 1'b1);
    check("pre_rst_hsync_low", 32'(b_hs), 32'(0));

    // asynchronous reset between edges while hsync is low
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_big", 32'(b_obs), 32'(RST_VAL));
    check("async_rst_small", 32'(s_obs), 32'(RST_VAL));
    repeat (3) @(posedge raw_clk);
    @(negedge raw_clk);
    rst = 1'b1;
    restart_counts();
    for (int i = 0; i < 3100; i++) tick(i < 100);
    check_line_timing("run2", 1'b0);

    // frame counter wrap on the small instance
    @(negedge raw_clk);
    rst = 1'b0;
    repeat (2) @(posedge raw_clk);
    @(negedge raw_clk);
    rst = 1'b1;
    restart_counts();
    for (int i = 0; i < 10; i++) tick(1'b1);
    @(negedge raw_clk);
    force dut_small.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_small.frame_cnt_q;
    s_fbase = 32'hFFFF;
    check("forced_leds", 32'(s_leds), 32'(16'hFFFF));
    for (int i = 0; i < 60; i++) tick(1'b1);
    check("wrap_leds", 32'(s_leds), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
